// File: rtl/petersen_edge_seq.sv
// petersen_edge_seq
// Walks the 15 edges of a Petersen graph and hands each one, in a fixed order,
// to a downstream line-drawing stage. For each edge it loads the endpoints,
// issues a one-cycle start pulse, waits for the line stage's completion pulse,
// and then idles for GAP cycles before moving to the next edge.
//
// Ports
//   i_clk         sole clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_go          one-cycle request to draw the whole graph (only honoured when idle)
//   i_line_done   one-cycle completion pulse from the line stage (only honoured in WAIT)
//   o_line_start  one-cycle start pulse to the line stage
//   o_x1..o_y2    endpoint coordinates, ordered so that o_y1 <= o_y2
//   o_edge_idx    index 0..14 of the current edge
//   o_busy        high while a graph is being drawn
//   o_done        one-cycle pulse after the last edge completes
module petersen_edge_seq #(
  parameter logic [8:0] VX0 = 9'd120,
  parameter logic [8:0] VX1 = 9'd200,
  parameter logic [8:0] VX2 = 9'd170,
  parameter logic [8:0] VX3 = 9'd70,
  parameter logic [8:0] VX4 = 9'd40,
  parameter logic [8:0] VX5 = 9'd120,
  parameter logic [8:0] VX6 = 9'd160,
  parameter logic [8:0] VX7 = 9'd145,
  parameter logic [8:0] VX8 = 9'd95,
  parameter logic [8:0] VX9 = 9'd80,
  parameter logic [8:0] VY0 = 9'd40,
  parameter logic [8:0] VY1 = 9'd98,
  parameter logic [8:0] VY2 = 9'd190,
  parameter logic [8:0] VY3 = 9'd190,
  parameter logic [8:0] VY4 = 9'd98,
  parameter logic [8:0] VY5 = 9'd80,
  parameter logic [8:0] VY6 = 9'd110,
  parameter logic [8:0] VY7 = 9'd160,
  parameter logic [8:0] VY8 = 9'd160,
  parameter logic [8:0] VY9 = 9'd110,
  parameter int         GAP = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_go,
  input  logic       i_line_done,
  output logic       o_line_start,
  output logic [8:0] o_x1,
  output logic [8:0] o_y1,
  output logic [8:0] o_x2,
  output logic [8:0] o_y2,
  output logic [3:0] o_edge_idx,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [89:0] VX_ALL = {VX9, VX8, VX7, VX6, VX5, VX4, VX3, VX2, VX1, VX0};
  localparam logic [89:0] VY_ALL = {VY9, VY8, VY7, VY6, VY5, VY4, VY3, VY2, VY1, VY0};
  localparam int          CW     = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP);
  localparam logic [3:0]  LAST_EDGE = 4'd14;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP, S_FIN} state_t;

  // Vertex coordinate lookup tables unpacked from the parameters.
  logic [8:0] vx_tab [10];
  logic [8:0] vy_tab [10];

  for (genvar gi = 0; gi < 10; gi++) begin : g_vtx
    assign vx_tab[gi] = VX_ALL[gi*9 +: 9];
    assign vy_tab[gi] = VY_ALL[gi*9 +: 9];
  end

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    idx_reg, idx_next;
  logic [8:0]    x1_reg, x1_next, y1_reg, y1_next;
  logic [8:0]    x2_reg, x2_next, y2_reg, y2_next;
  logic          start_reg, start_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  // Edge table: outer ring, spokes, inner pentagram.
  logic [3:0] va, vb;
  always_comb begin
    va = 4'd0;
    vb = 4'd1;
    case (idx_reg)
      4'd0:  begin va = 4'd0; vb = 4'd1; end
      4'd1:  begin va = 4'd1; vb = 4'd2; end
      4'd2:  begin va = 4'd2; vb = 4'd3; end
      4'd3:  begin va = 4'd3; vb = 4'd4; end
      4'd4:  begin va = 4'd4; vb = 4'd0; end
      4'd5:  begin va = 4'd0; vb = 4'd5; end
      4'd6:  begin va = 4'd1; vb = 4'd6; end
      4'd7:  begin va = 4'd2; vb = 4'd7; end
      4'd8:  begin va = 4'd3; vb = 4'd8; end
      4'd9:  begin va = 4'd4; vb = 4'd9; end
      4'd10: begin va = 4'd5; vb = 4'd7; end
      4'd11: begin va = 4'd7; vb = 4'd9; end
      4'd12: begin va = 4'd9; vb = 4'd6; end
      4'd13: begin va = 4'd6; vb = 4'd8; end
      4'd14: begin va = 4'd8; vb = 4'd5; end
      default: begin va = 4'd0; vb = 4'd1; end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    x1_next    = x1_reg;
    y1_next    = y1_reg;
    x2_next    = x2_reg;
    y2_next    = y2_reg;
    start_next = 1'b0;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_go) begin
          idx_next   = 4'd0;
          busy_next  = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        // Lower-y endpoint goes first; on a tie the table order is kept.
        if (vy_tab[va] > vy_tab[vb]) begin
          x1_next = vx_tab[vb];
          y1_next = vy_tab[vb];
          x2_next = vx_tab[va];
          y2_next = vy_tab[va];
        end else begin
          x1_next = vx_tab[va];
          y1_next = vy_tab[va];
          x2_next = vx_tab[vb];
          y2_next = vy_tab[vb];
        end
        state_next = S_START;
      end
      S_START: begin
        start_next = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_line_done) begin
          cnt_next   = GAP_LOAD;
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        // A zero count leaves on the first GAP cycle, so GAP=0 is one pass.
        if (cnt_reg == '0) begin
          if (idx_reg == LAST_EDGE) begin
            state_next = S_FIN;
          end else begin
            idx_next   = idx_reg + 4'd1;
            state_next = S_LOAD;
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_FIN: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 4'd0;
      x1_reg    <= 9'd0;
      y1_reg    <= 9'd0;
      x2_reg    <= 9'd0;
      y2_reg    <= 9'd0;
      start_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      x1_reg    <= x1_next;
      y1_reg    <= y1_next;
      x2_reg    <= x2_next;
      y2_reg    <= y2_next;
      start_reg <= start_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign o_line_start = start_reg;
  assign o_x1         = x1_reg;
  assign o_y1         = y1_reg;
  assign o_x2         = x2_reg;
  assign o_y2         = y2_reg;
  assign o_edge_idx   = idx_reg;
  assign o_busy       = busy_reg;
  assign o_done       = done_reg;

endmodule

// File: tb/tb_petersen_edge_seq.sv
// Testbench for petersen_edge_seq: randomized line-stage response delays and
// spurious i_go / i_line_done pulses, checked against a graph-level model
// (vertex table + edge list + y-ordering rule + cycle latencies).
module tb_petersen_edge_seq;

  localparam int GAP_A = 4;

  logic       clk = 1'b0;
  logic       rst_n, go, line_done;
  logic       ls, busy, done;
  logic [8:0] x1, y1, x2, y2;
  logic [3:0] idx;
  logic       ls0, busy0, done0;
  logic [8:0] x10, y10, x20, y20;
  logic [3:0] idx0;

  int checks = 0;
  int errors = 0;

  int vx [10] = '{120, 200, 170, 70, 40, 120, 160, 145, 95, 80};
  int vy [10] = '{40, 98, 190, 190, 98, 80, 110, 160, 160, 110};
  int ea [15];
  int eb [15];

  always #5 clk = ~clk;

  petersen_edge_seq u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_line_done(line_done),
    .o_line_start(ls), .o_x1(x1), .o_y1(y1), .o_x2(x2), .o_y2(y2),
    .o_edge_idx(idx), .o_busy(busy), .o_done(done)
  );

  petersen_edge_seq #(.GAP(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_line_done(line_done),
    .o_line_start(ls0), .o_x1(x10), .o_y1(y10), .o_x2(x20), .o_y2(y20),
    .o_edge_idx(idx0), .o_busy(busy0), .o_done(done0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected endpoints of edge e: lower-y vertex first, ties keep table order.
  task automatic model_edge(input int e, output int ex1, output int ey1, output int ex2, output int ey2);
    int a, b;
    a = ea[e];
    b = eb[e];
    if (vy[a] > vy[b]) begin
      int t;
      t = a; a = b; b = t;
    end
    ex1 = vx[a]; ey1 = vy[a]; ex2 = vx[b]; ey2 = vy[b];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ls"}, ls, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_idx"}, idx, 0);
    check({tag, "_xy"}, {x1, y1, x2, y2}, 0);
  endtask

  task automatic see_start(input int e);
    int ex1, ey1, ex2, ey2;
    model_edge(e, ex1, ey1, ex2, ey2);
    check($sformatf("e%0d_start", e), ls, 1);
    check($sformatf("e%0d_idx", e), idx, e);
    check($sformatf("e%0d_busy", e), busy, 1);
    check($sformatf("e%0d_x1", e), x1, ex1);
    check($sformatf("e%0d_y1", e), y1, ey1);
    check($sformatf("e%0d_x2", e), x2, ex2);
    check($sformatf("e%0d_y2", e), y2, ey2);
    check($sformatf("e%0d_yorder", e), (y1 <= y2), 1);
    // Worked examples quoted directly as literals.
    case (e)
      0:  check("ex_e0",  {x1, y1, x2, y2}, {9'd120, 9'd40, 9'd200, 9'd98});
      2:  check("ex_e2",  {x1, y1, x2, y2}, {9'd170, 9'd190, 9'd70, 9'd190});
      3:  check("ex_e3",  {x1, y1, x2, y2}, {9'd40, 9'd98, 9'd70, 9'd190});
      10: check("ex_e10", {x1, y1, x2, y2}, {9'd120, 9'd80, 9'd145, 9'd160});
      14: check("ex_e14", {x1, y1, x2, y2}, {9'd120, 9'd80, 9'd95, 9'd160});
      default: ;
    endcase
  endtask

  // Draw edges 0..last_edge on u_dut. With full=0 it returns in the WAIT
  // cycle right after the start pulse of last_edge.
  task automatic run(input int last_edge, input bit full);
    int dly;
    logic [8:0] hold_x1;
    go = 1'b1;
    tick();
    go = 1'b0;
    check("go_busy", busy, 1);
    check("go_ls_t1", ls, 0);
    tick();
    check("go_ls_t2", ls, 0);
    tick();
    for (int e = 0; e <= last_edge; e++) begin
      see_start(e);
      $display("edge %0d start idx=%0d (%0d,%0d)-(%0d,%0d)", e, idx, x1, y1, x2, y2);
      if (!full && e == last_edge) return;
      hold_x1 = x1;
      dly = $urandom_range(1, 12);
      repeat (dly) begin
        go = 1'($urandom_range(0, 1));
        tick();
        go = 1'b0;
        check("ls_width", ls, 0);
        check("xy_stable", x1, hold_x1);
      end
      line_done = 1'b1;
      tick();
      line_done = 1'b0;
      if (e < 14) begin
        for (int k = 1; k <= GAP_A + 3; k++) begin
          check("ls_gap", ls, 0);
          check("done_early", done, 0);
          if (k == 1) begin
            line_done = 1'b1;
            go = 1'b1;
          end
          tick();
          line_done = 1'b0;
          go = 1'b0;
        end
      end else begin
        for (int k = 1; k <= GAP_A + 2; k++) begin
          check("done_early", done, 0);
          check("ls_tail", ls, 0);
          if (k == 1) line_done = 1'b1;
          tick();
          line_done = 1'b0;
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_idx", idx, 14);
        check("done_xy", {x1, y1, x2, y2}, {9'd120, 9'd80, 9'd95, 9'd160});
        $display("done idx=%0d", idx);
        tick();
        check("done_width", done, 0);
        check("idle_busy", busy, 0);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 5; k++) begin
      ea[k] = k;      eb[k] = (k + 1) % 5;
      ea[k + 5] = k;  eb[k + 5] = k + 5;
    end
    ea[10] = 5; eb[10] = 7;
    ea[11] = 7; eb[11] = 9;
    ea[12] = 9; eb[12] = 6;
    ea[13] = 6; eb[13] = 8;
    ea[14] = 8; eb[14] = 5;

    rst_n = 1'b0;
    go = 1'b0;
    line_done = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    check("rst0_idx", idx0, 0);
    rst_n = 1'b1;
    tick();

    // Full graph with random response delays and spurious pulses.
    run(14, 1'b1);
    repeat (5) begin
      tick();
      check("idle_ls", ls, 0);
      check("idle_done", done, 0);
    end

    // Abort during edge 7 WAIT, then restart from edge 0.
    run(7, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("abort");
    $display("abort reset applied during edge 7");
    repeat (20) begin
      tick();
      check("abort_no_done", done, 0);
      check("abort_no_ls", ls, 0);
    end
    run(14, 1'b1);

    // GAP=0 latency against GAP=4, both started together.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    check("g0_first_ls", ls0, 1);
    check("g4_first_ls", ls, 1);
    tick();
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
    tick();
    tick();
    check("g0_ls_d3", ls0, 0);
    tick();
    check("g0_ls_d4", ls0, 1);
    check("g0_idx", idx0, 1);
    check("g0_xy", {x10, y10, x20, y20}, {9'd200, 9'd98, 9'd170, 9'd190});
    $display("gap0 second start idx=%0d", idx0);
    repeat (3) begin
      tick();
      check("g4_ls_pre", ls, 0);
    end
    tick();
    check("g4_ls_d8", ls, 1);
    check("g4_idx", idx, 1);
    $display("gap4 second start idx=%0d", idx);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/petersen_edge_seq.md
PETERSEN_EDGE_SEQ -- requirements
Module: petersen_edge_seq

Interface
- REQ-001: Parameter VX0..VX9, 9 bits each, defaults 120,200,170,70,40,120,160,145,95,80; x-coordinate of vertex 0..9.
- REQ-002: Parameter VY0..VY9, 9 bits each, defaults 40,98,190,190,98,80,110,160,160,110; y-coordinate of vertex 0..9.
- REQ-003: Parameter GAP, default 4; idle cycles inserted after each line completes, before the next line is loaded.
- REQ-004: i_clk  in  1  sole clock; all logic on rising edge.
- REQ-005: i_rst_n  in  1  synchronous, active-low reset.
- REQ-006: i_go  in  1  one-cycle request to draw the full graph.
- REQ-007: i_line_done  in  1  one-cycle completion pulse from the downstream line-drawing stage.
- REQ-008: o_line_start  out  1  one-cycle start pulse to the line stage.
- REQ-009: o_x1, o_y1, o_x2, o_y2  out  9 each  endpoint coordinates to the line stage.
- REQ-010: o_edge_idx  out  4  index (0..14) of the current edge.
- REQ-011: o_busy  out  1  high from the cycle after i_go is accepted until o_done.
- REQ-012: o_done  out  1  one-cycle pulse when all 15 edges are finished.

Function
- REQ-013: Edge table is fixed: idx 0..4 = outer (0,1),(1,2),(2,3),(3,4),(4,0); idx 5..9 = spokes (k,k+5) for k=0..4; idx 10..14 = inner (5,7),(7,9),(9,6),(6,8),(8,5).
- REQ-014: State machine states: IDLE, LOAD, START, WAIT, GAP, FIN.
- REQ-015: IDLE: i_go=1 -> LOAD with o_edge_idx=0 and o_busy=1; i_go is ignored in every other state.
- REQ-016: LOAD (1 cycle): register the endpoints of edge o_edge_idx -> START.
- REQ-017: Endpoint ordering: for edge (a,b), if VYa > VYb then (x1,y1)=(VXb,VYb) and (x2,y2)=(VXa,VYa); otherwise (x1,y1)=(VXa,VYa) and (x2,y2)=(VXb,VYb). This guarantees o_y1 <= o_y2; ties keep table order.
- REQ-018: START (1 cycle): o_line_start=1 -> WAIT. o_line_start SHALL be high in no other state.
- REQ-019: o_x1, o_y1, o_x2, o_y2 SHALL be stable from the end of LOAD until the next LOAD, or until reset.
- REQ-020: WAIT: hold until i_line_done=1; then -> GAP with the counter loaded to GAP. No timeout. An i_line_done seen outside WAIT is ignored.
- REQ-021: GAP: decrement the counter each cycle; when it reaches 0, if o_edge_idx==14 -> FIN, else increment o_edge_idx -> LOAD. GAP=0 means a single pass through GAP.
- REQ-022: FIN (1 cycle): o_done=1, o_busy=0 -> IDLE; o_edge_idx and the coordinates keep their last values.
- REQ-023: Latency: i_go at cycle T -> first o_line_start at T+3. i_line_done at cycle D -> next o_line_start at D+GAP+4.

Reset
- REQ-024: While i_rst_n=0 at a clock edge, the next state is IDLE and the outputs are o_line_start=0, o_done=0, o_busy=0, o_edge_idx=0, and all coordinates 0.
- REQ-025: Reset asserted mid-line aborts the sequence with no o_done. A following i_go restarts at edge 0.

Verification
- REQ-026: Reset, then i_go -> o_line_start after 3 cycles with (x1,y1,x2,y2)=(120,40,200,98) and o_edge_idx=0.
- REQ-027: Model answers i_line_done 10 cycles after each start -> exactly 15 o_line_start pulses, idx 0..14 in order, then one o_done. Edge 3 gives (40,98,70,190) (swapped). Edge 2 gives (170,190,70,190) (tie, unswapped).
- REQ-028: Edge 10 (5,7) gives (120,80,145,160). Edge 14 (8,5) gives (120,80,95,160) (swapped). Check o_y1 <= o_y2 on every edge.
- REQ-029: i_go and spurious i_line_done pulses while busy -> no change to sequence or idx; o_line_start stays one cycle wide.
- REQ-030: i_rst_n=0 for 1 cycle during edge 7 WAIT -> all outputs at reset values next cycle, no o_done. A new i_go restarts at edge 0.
- REQ-031: GAP=0 and i_line_done at cycle D -> next o_line_start at D+4.
